// File: rtl/iom_bus_slave.sv
module iom_bus_slave #(
  parameter int unsigned       ADDR_W      = 20,
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       MEM_AW      = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CS,
  input  logic              ALE,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  output logic              READY,
  output logic              ERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_READ,
    ST_WRITE,
    ST_HOLD,
    ST_ERROR
  } state_t;

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int unsigned CW        = (DATA_W < 16) ? DATA_W : 16;

  state_t              state;
  logic [ADDR_W-1:0]   addr_reg;
  logic                space_reg;
  logic                rd_cap;
  logic [3:0]          wcnt;
  logic [DATA_W-1:0]   reg0;
  logic [DATA_W-1:0]   reg1;
  logic [DATA_W-1:0]   reg2;
  logic [15:0]         txn_cnt;
  logic                data_oe;

  logic [DATA_W-1:0]   mem [2**MEM_AW];
  logic [MEM_AW-1:0]   mem_idx;
  logic                hit;
  logic                mem_we;
  logic [DATA_W-1:0]   cnt_word;
  logic [DATA_W-1:0]   rd_data;

  assign mem_idx = addr_reg[MEM_AW-1:0];
  assign hit     = !space_reg || (addr_reg[ADDR_W-1:MEM_AW] == BASE_ADDR[ADDR_W-1:MEM_AW]);
  assign mem_we  = (state == ST_WRITE) && space_reg;
  assign Data    = data_oe ? rd_data : 'z;

  always_comb begin
    cnt_word = '0;
    for (int unsigned i = 0; i < CW; i++) begin
      cnt_word[i] = txn_cnt[i];
    end
  end

  always_comb begin
    rd_data = '0;
    if (space_reg) begin
      rd_data = mem[mem_idx];
    end else begin
      case (addr_reg[1:0])
        2'd0:    rd_data = reg0;
        2'd1:    rd_data = reg1;
        2'd2:    rd_data = reg2;
        default: rd_data = cnt_word;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain; the write only fires in ST_WRITE.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_idx] <= Data;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      addr_reg  <= '0;
      space_reg <= 1'b0;
      rd_cap    <= 1'b0;
      wcnt      <= '0;
      reg0      <= '0;
      reg1      <= '0;
      reg2      <= '0;
      txn_cnt   <= '0;
      data_oe   <= 1'b0;
      READY     <= 1'b1;
      ERR       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CS && ALE) begin
            addr_reg  <= Address;
            space_reg <= IOM;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!hit) begin
            state <= ST_IDLE;
          end else if (!RD && !WR) begin
            state <= ST_ERROR;
            ERR   <= 1'b1;
          end else if (!RD || !WR) begin
            rd_cap <= !RD;
            if (WAIT_CYCLES != 0) begin
              state <= ST_WAIT;
              wcnt  <= WAIT_INIT;
              READY <= 1'b0;
            end else if (!RD) begin
              state   <= ST_READ;
              data_oe <= 1'b1;
            end else begin
              state <= ST_WRITE;
            end
          end
        end
        // Counter value 1 marks the last wait cycle, so WAIT lasts exactly WAIT_CYCLES cycles.
        ST_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (rd_cap ? RD : WR) begin
            state <= ST_IDLE;
            READY <= 1'b1;
          end else if (wcnt <= 4'd1) begin
            READY <= 1'b1;
            if (rd_cap) begin
              state   <= ST_READ;
              data_oe <= 1'b1;
            end else begin
              state <= ST_WRITE;
            end
          end
        end
        ST_READ: begin
          if (RD) begin
            state   <= ST_IDLE;
            data_oe <= 1'b0;
            txn_cnt <= txn_cnt + 16'd1;
          end
        end
        ST_WRITE: begin
          if (!space_reg) begin
            case (addr_reg[1:0])
              2'd0:    reg0 <= Data;
              2'd1:    reg1 <= Data;
              2'd2:    reg2 <= Data;
              default: ;
            endcase
          end
          txn_cnt <= txn_cnt + 16'd1;
          state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (WR) begin
            state <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (RD && WR) begin
            state <= ST_IDLE;
            ERR   <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          data_oe <= 1'b0;
          READY   <= 1'b1;
          ERR     <= 1'b0;
        end
      endcase
    end
  end

endmodule
